// File: rtl/onchip_mem_pkg.sv
// rtl/onchip_mem_pkg.sv - shared constants, state and pattern-mode encodings for the on-chip memory BIST
package onchip_mem_pkg;

    localparam int DEPTH  = 15360;
    localparam int ADDR_W = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } bist_state_t;

    localparam logic [1:0] MODE_SEED = 2'd0;
    localparam logic [1:0] MODE_XOR  = 2'd1;
    localparam logic [1:0] MODE_XNOR = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

endpackage

// File: rtl/onchip_mem_bist_pattern.sv
// rtl/onchip_mem_bist_pattern.sv - combinational test pattern generator pattern(address, mode, seed)
module onchip_mem_bist_pattern
    import onchip_mem_pkg::*;
#(
    parameter int ADDR_W = onchip_mem_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] address,
    input  logic [1:0]        mode,
    input  logic [15:0]       seed,
    output logic [15:0]       pattern
);

    logic [15:0] addr_ext;

    assign addr_ext = {{(16-ADDR_W){1'b0}}, address};

    // Select the pattern; the reserved mode falls back to the plain seed
    always_comb begin
        pattern = seed;
        case (mode)
            MODE_XOR:  pattern = addr_ext ^ seed;
            MODE_XNOR: pattern = ~(addr_ext ^ seed);
            default:   pattern = seed;
        endcase
    end

endmodule

// File: rtl/onchip_mem_bist.sv
// rtl/onchip_mem_bist.sv - Avalon-MM write/read-back/compare self-test engine for the 16-bit on-chip memory
module onchip_mem_bist
    import onchip_mem_pkg::*;
#(
    parameter int DEPTH        = onchip_mem_pkg::DEPTH,
    parameter int ADDR_W       = onchip_mem_pkg::ADDR_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   length,
    input  logic [1:0]        mode,
    input  logic [15:0]       seed,
    input  logic              hold,
    output logic [ADDR_W-1:0] address,
    output logic [1:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [15:0]       writedata,
    output logic              clken,
    input  logic [15:0]       readdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              cfg_err
);

    bist_state_t state, state_nxt;

    // Run configuration captured at an accepted start
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W:0]   len_r;
    logic [1:0]        mode_r;
    logic [15:0]       seed_r;
    logic [ADDR_W:0]   idx;

    // Read tracking pipeline: valid bit and word address per outstanding read
    logic [READ_LATENCY-1:0] pipe_v;
    logic [ADDR_W-1:0]       pipe_a [READ_LATENCY];
    logic                    pipe_pending;

    logic [15:0]       err_cnt;
    logic [15:0]       err_next;
    logic              first_seen;
    logic [ADDR_W-1:0] first_err_r;
    logic [15:0]       err_count_r;
    logic              pass_r;
    logic              cfg_err_r;

    logic [ADDR_W+1:0] end_sum;
    logic              range_bad;
    logic              start_accept;
    logic              start_reject;
    logic              issue;
    logic              last_word;
    logic [ADDR_W-1:0] cur_addr;
    logic [15:0]       wr_pattern;
    logic [15:0]       exp_word;
    logic              cmp_valid;
    logic              mismatch;

    assign end_sum      = {2'b00, base} + {1'b0, length};
    assign range_bad    = end_sum > (ADDR_W+2)'(DEPTH);
    assign start_accept = (state == ST_IDLE) && start && !range_bad;
    assign start_reject = (state == ST_IDLE) && start && range_bad;
    assign cur_addr     = base_r + idx[ADDR_W-1:0];
    assign last_word    = (idx == len_r - 1'b1);
    assign issue        = ((state == ST_WRITE) || (state == ST_READ)) && !hold;

    assign cmp_valid = pipe_v[READ_LATENCY-1];
    assign mismatch  = cmp_valid && (readdata != exp_word);
    assign err_next  = (mismatch && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;

    onchip_mem_bist_pattern #(.ADDR_W(ADDR_W)) u_wr_pattern (
        .address (cur_addr),
        .mode    (mode_r),
        .seed    (seed_r),
        .pattern (wr_pattern)
    );

    onchip_mem_bist_pattern #(.ADDR_W(ADDR_W)) u_exp_pattern (
        .address (pipe_a[READ_LATENCY-1]),
        .mode    (mode_r),
        .seed    (seed_r),
        .pattern (exp_word)
    );

    // Any read still short of the compare stage keeps DRAIN waiting
    always_comb begin
        pipe_pending = 1'b0;
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
            pipe_pending = pipe_pending | pipe_v[i];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and bus command decode
    always_comb begin
        state_nxt  = state;
        chipselect = 1'b0;
        write      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_accept) begin
                    state_nxt = (length == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!hold) begin
                    chipselect = 1'b1;
                    write      = 1'b1;
                    if (last_word) state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (!hold) begin
                    chipselect = 1'b1;
                    if (last_word) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!pipe_pending) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Configuration capture, word counter, read pipeline and result tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_r      <= '0;
            len_r       <= '0;
            mode_r      <= '0;
            seed_r      <= '0;
            idx         <= '0;
            pipe_v      <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe_a[i] <= '0;
            err_cnt     <= '0;
            first_seen  <= 1'b0;
            first_err_r <= '0;
            err_count_r <= '0;
            pass_r      <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            cfg_err_r <= start_reject;

            pipe_v[0] <= issue && (state == ST_READ);
            pipe_a[0] <= cur_addr;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end

            if (start_accept) begin
                base_r      <= base;
                len_r       <= length;
                mode_r      <= mode;
                seed_r      <= seed;
                idx         <= '0;
                err_cnt     <= '0;
                first_seen  <= 1'b0;
                first_err_r <= '0;
                err_count_r <= '0;
                pass_r      <= (length == '0);
            end else begin
                if (issue) begin
                    idx <= last_word ? '0 : idx + 1'b1;
                end
                err_cnt <= err_next;
                if (mismatch && !first_seen) begin
                    first_seen  <= 1'b1;
                    first_err_r <= pipe_a[READ_LATENCY-1];
                end
                if ((state == ST_DRAIN) && (state_nxt == ST_DONE)) begin
                    err_count_r <= err_next;
                    pass_r      <= (err_next == 16'd0);
                end
            end
        end
    end

    assign address        = chipselect ? cur_addr : '0;
    assign writedata      = (chipselect && write) ? wr_pattern : 16'd0;
    assign byteenable     = chipselect ? 2'b11 : 2'b00;
    assign clken          = reset_n;
    assign busy           = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
    assign done           = (state == ST_DONE);
    assign pass           = pass_r;
    assign err_count      = err_count_r;
    assign first_err_addr = first_err_r;
    assign cfg_err        = cfg_err_r;

endmodule

// File: tb/tb_onchip_mem_bist.sv
// tb/tb_onchip_mem_bist.sv - directed self-checking bench for onchip_mem_bist with a behavioural memory
module tb_onchip_mem_bist;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] base = '0;
    logic [14:0] length = '0;
    logic [1:0]  mode = '0;
    logic [15:0] seed = '0;
    logic        hold = 1'b0;
    logic [13:0] address;
    logic [1:0]  byteenable;
    logic        chipselect;
    logic        write;
    logic [15:0] writedata;
    logic        clken;
    logic [15:0] readdata = '0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [13:0] first_err_addr;
    logic        cfg_err;

    logic [15:0] mem [0:15359];
    bit          fault_en = 1'b0;

    int n_asserts = 0;
    int n_fail    = 0;
    int n_cmd, n_wr, done_cyc, hold_cs, be_bad, cfg_seen, busy_gap, bad_cnt;

    always #5 clk = ~clk;

    onchip_mem_bist dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base           (base),
        .length         (length),
        .mode           (mode),
        .seed           (seed),
        .hold           (hold),
        .address        (address),
        .byteenable     (byteenable),
        .chipselect     (chipselect),
        .write          (write),
        .writedata      (writedata),
        .clken          (clken),
        .readdata       (readdata),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .cfg_err        (cfg_err)
    );

    // Behavioural single-port memory, one-cycle read latency, optional bit 3 stuck-at-0 at word 5
    always @(posedge clk) begin
        if (chipselect && write) mem[address] <= writedata;
        if (chipselect && !write)
            readdata <= (fault_en && address == 14'd5) ? (mem[address] & 16'hFFF7) : mem[address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [13:0] b, input logic [14:0] l, input logic [1:0] m,
                       input logic [15:0] s, input int h_from, input int h_len, input int rs_at);
        n_cmd = 0; n_wr = 0; done_cyc = -1; hold_cs = 0; be_bad = 0; cfg_seen = 0; busy_gap = 0;
        @(negedge clk);
        base = b; length = l; mode = m; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            hold  = (cyc >= h_from) && (cyc < h_from + h_len);
            start = (cyc == rs_at);
            if (cyc == rs_at) begin
                base = 14'd15350; length = 15'd11;
            end
            #1;
            if (chipselect) begin
                n_cmd++;
                if (write) n_wr++;
                if (byteenable !== 2'b11) be_bad++;
                if (hold) hold_cs++;
            end
            if (cfg_err) cfg_seen++;
            if (done) begin
                done_cyc = cyc;
                if (busy) busy_gap++;
                break;
            end
            if (!busy) busy_gap++;
            @(negedge clk);
        end
        hold = 1'b0; start = 1'b0;
        check("run_timeout", (done_cyc > 0), 1);
    endtask

    initial begin
        #1;
        check("rst_chipselect", chipselect, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_clken", clken, 0);
        check("rst_pass", pass, 0);
        check("rst_err_count", err_count, 0);
        check("rst_first_err", first_err_addr, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_byteenable", byteenable, 0);
        #11 reset_n = 1'b1;
        #1 check("clken_after_rst", clken, 1);

        // Clean run, address-xor-seed pattern
        run(14'd0, 15'd16, 2'd1, 16'hA5A5, 0, 0, 0);
        check("t1_done_cycle", done_cyc, 34);
        check("t1_cmds", n_cmd, 32);
        check("t1_writes", n_wr, 16);
        check("t1_pass", pass, 1);
        check("t1_err_count", err_count, 0);
        check("t1_first_err", first_err_addr, 0);
        check("t1_byteenable", be_bad, 0);
        check("t1_busy", busy_gap, 0);
        check("t1_mem0", mem[0], 16'hA5A5);
        check("t1_mem5", mem[5], 16'hA5A0);
        check("t1_mem15", mem[15], 16'hA5AA);
        @(negedge clk);
        #1;
        check("t1_done_pulse", done, 0);
        check("t1_pass_held", pass, 1);

        // Bit 3 stuck at 0 on word 5; seed chosen so the pattern has bit 3 set there
        fault_en = 1'b1;
        run(14'd0, 15'd16, 2'd1, 16'h5A5A, 0, 0, 0);
        fault_en = 1'b0;
        check("t2_done_cycle", done_cyc, 34);
        check("t2_pass", pass, 0);
        check("t2_err_count", err_count, 1);
        check("t2_first_err", first_err_addr, 5);

        // Zero-length run
        run(14'd7, 15'd0, 2'd0, 16'h1111, 0, 0, 0);
        check("t3_done_cycle", done_cyc, 1);
        check("t3_cmds", n_cmd, 0);
        check("t3_pass", pass, 1);
        check("t3_err_count", err_count, 0);

        // Range past the end of memory is rejected
        @(negedge clk);
        base = 14'd15350; length = 15'd11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("t4_cfg_err", cfg_err, 1);
        check("t4_busy", busy, 0);
        bad_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (chipselect || busy || cfg_err || done) bad_cnt++;
        end
        check("t4_quiet", bad_cnt, 0);
        check("t4_pass_held", pass, 1);

        // Range ending exactly at the last word is accepted
        run(14'd15350, 15'd10, 2'd0, 16'h3C3C, 0, 0, 0);
        check("t5_done_cycle", done_cyc, 22);
        check("t5_cmds", n_cmd, 20);
        check("t5_pass", pass, 1);
        check("t5_cfg", cfg_seen, 0);
        check("t5_mem_last", mem[15359], 16'h3C3C);

        // Inverted pattern, hold for cycles 11..13 of the read phase, stray start mid-run
        run(14'd100, 15'd8, 2'd2, 16'h0F0F, 11, 3, 4);
        check("t6_done_cycle", done_cyc, 21);
        check("t6_cmds", n_cmd, 16);
        check("t6_cs_in_hold", hold_cs, 0);
        check("t6_cfg", cfg_seen, 0);
        check("t6_pass", pass, 1);
        check("t6_mem100", mem[100], 16'hF094);
        check("t6_mem107", mem[107], 16'hF09B);

        // Reset in the middle of the write phase, then a normal run
        @(negedge clk);
        base = 14'd200; length = 15'd16; mode = 2'd0; seed = 16'h1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("t7_writing", chipselect && write, 1);
        reset_n = 1'b0;
        #1;
        check("t7_rst_cs", chipselect, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_done", done, 0);
        check("t7_rst_clken", clken, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run(14'd200, 15'd16, 2'd0, 16'h1234, 0, 0, 0);
        check("t7_done_cycle", done_cyc, 34);
        check("t7_pass", pass, 1);
        check("t7_err_count", err_count, 0);
        check("t7_mem215", mem[215], 16'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/onchip_mem_bist.md
# onchip_mem_bist

Avalon-MM master engine that drives the 16-bit single-port on-chip memory slave (14-bit word address, 15360 words, 2-bit byteenable, one-cycle read latency). On a start pulse it writes a deterministic pattern over a word range, reads the range back, compares each word, and reports pass/fail, the error count and the first failing address. It sits beside the Nios II data master on the memory's second slave port and is used for power-on self test and lab bring-up.

## Interface

Parameters:
- DEPTH, 15360, number of 16-bit words in the target memory.
- ADDR_W, 14, word address width.
- READ_LATENCY, 1, cycles from read-command cycle to valid readdata; fixed pipeline, no waitrequest.

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base  in  ADDR_W  first word address of the range.
- length  in  ADDR_W+1  number of words to test.
- mode  in  2  pattern: 0 = seed, 1 = address XOR seed, 2 = ~(address XOR seed), 3 = treated as 0.
- seed  in  16  pattern seed.
- hold  in  1  pauses issue of new commands; in-flight reads still complete.
- address  out  ADDR_W  memory word address.
- byteenable  out  2  always 2'b11 while chipselect is high, else 0.
- chipselect  out  1  command valid.
- write  out  1  1 = write command, 0 = read (meaningful only with chipselect).
- writedata  out  16  pattern word.
- clken  out  1  memory clock enable; 1 whenever out of reset.
- readdata  in  16  memory read data.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion.
- pass  out  1  result of last run; held until next accepted start.
- err_count  out  16  mismatches in last run, saturating at 16'hFFFF.
- first_err_addr  out  ADDR_W  address of first mismatch; 0 if none.
- cfg_err  out  1  one-cycle pulse when start is rejected.

## Operation

- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: on start, if base + length > DEPTH, stay in IDLE and pulse cfg_err; if length = 0, go directly to DONE with pass = 1 and err_count = 0; otherwise clear err_count, first_err_addr, and the first-error flag, load the word counter, and go to WRITE.
- WRITE: each non-hold cycle issues chipselect=1, write=1, address = base + i, writedata = pattern(address). After the last word, go to READ.
- READ: each non-hold cycle issues chipselect=1, write=0 at base + i. An expected-data/valid shift pipeline of depth READ_LATENCY tracks each read. After the last issue, go to DRAIN.
- DRAIN: wait until the pipeline is empty, then go to DONE.
- Compare: when a pipeline entry becomes valid, compare readdata with the expected word. On mismatch, increment err_count (saturating) and latch first_err_addr on the first mismatch only.
- DONE: pulse done for one cycle, set pass = (err_count == 0), return to IDLE.
- hold: chipselect is low in every hold cycle and the counters freeze. The compare pipeline keeps advancing.
- start while busy is ignored and does not raise cfg_err.
- Address arithmetic is unsigned ADDR_W+1 bits, so no wrap past DEPTH-1 is possible once a start is accepted.

## Timing

- Reset (asynchronous, effective immediately): IDLE; all outputs 0 except clken, which is 1 after reset deasserts. An in-progress run is abandoned and no done pulse is produced.
- start accepted at edge 0: busy high from cycle 1. Writes occupy cycles 1..N, reads occupy cycles N+1..2N (no hold).
- The last compare happens in cycle 2N+READ_LATENCY. done, pass and err_count update in cycle 2N+READ_LATENCY+1; busy falls in the same cycle.
- Each hold cycle adds exactly one cycle to the total.
- length = 0: done pulses in cycle 1.
- cfg_err pulses in cycle 1; busy stays low.

## Structure

- Shared package onchip_mem_pkg: DEPTH, ADDR_W, the state enum, and the mode encodings.
- One sub-module, onchip_mem_bist_pattern: a combinational pattern(address, mode, seed) function block, instantiated twice (write data and expected data).

## Test plan

- Run with base=0, length=16, mode=1, seed=16'hA5A5 against a behavioural memory model: 32 commands, done in cycle 34, pass=1, err_count=0.
- Same run with the model forcing bit 3 at address 5 stuck at 0: pass=0, err_count=1, first_err_addr=5.
- Start with base=15350, length=11: cfg_err pulse, busy stays low, no chipselect.
- Start with length=0: done in cycle 1, pass=1, no bus activity.
- mode=2, length=8, with hold high for 3 cycles mid-read: done is delayed by exactly 3 cycles, no chipselect during hold, pass=1.
- Assert reset_n low mid-WRITE: chipselect, busy and done drop immediately; after release a new start completes normally.
